// File: rtl/gf_divider.sv
// Sequential dual-mode divider: shift-and-subtract with XOR (GF(2)[x]) or borrow-subtract (unsigned integer).
// Optional macro GF_DIV_ZERO_FLAG_EN adds a div_by_zero port and a short path for a zero divisor.
module gf_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         gf_option,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
`ifdef GF_DIV_ZERO_FLAG_EN
    ,
    output logic         div_by_zero
`endif
);

    localparam int CW = $clog2(W + 1);
    localparam int DW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            gf_q, gf_d;
    logic [DW-1:0]   deg_q, deg_d;
    logic [W-1:0]    r_q, r_d;
    logic [W-1:0]    q_q, q_d;
`ifdef GF_DIV_ZERO_FLAG_EN
    logic            zf_q, zf_d;
    logic            dz_q, dz_d;
`endif

    logic [W:0]      r_sh;
    logic [W-1:0]    g_sh;
    logic            int_ge;
    logic            gf_hit;

    // Priority encoder: position of the most significant set bit.
    function automatic logic [DW-1:0] lead_one(input logic [W-1:0] v);
        lead_one = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) lead_one = DW'(i);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        a_d     = a_q;
        b_d     = b_q;
        gf_d    = gf_q;
        deg_d   = deg_q;
        r_d     = r_q;
        q_d     = q_q;
`ifdef GF_DIV_ZERO_FLAG_EN
        zf_d    = zf_q;
        dz_d    = dz_q;
`endif

        // Dividend bits are consumed MSB first by shifting a_q left each step.
        r_sh   = {r_q, a_q[W-1]};
        g_sh   = {r_q[W-2:0], a_q[W-1]};
        int_ge = (r_sh >= {1'b0, b_q});
        gf_hit = (b_q != '0) && g_sh[deg_q];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    gf_d    = gf_option;
                    deg_d   = lead_one(b);
                    r_d     = '0;
                    q_d     = '0;
                    cnt_d   = CW'(W);
                    state_d = S_RUN;
`ifdef GF_DIV_ZERO_FLAG_EN
                    zf_d    = (b == '0);
                    dz_d    = 1'b0;
                    // Zero divisor: preload the answer and finish after one RUN cycle.
                    if (b == '0) begin
                        r_d   = a;
                        cnt_d = '0;
                    end
`endif
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    quo_d   = q_q;
                    rem_d   = r_q;
                    state_d = S_FIN;
`ifdef GF_DIV_ZERO_FLAG_EN
                    dz_d    = zf_q;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    a_d   = a_q << 1;
                    if (gf_q) begin
                        r_d = gf_hit ? (g_sh ^ b_q) : g_sh;
                        q_d = {q_q[W-2:0], gf_hit};
                    end else begin
                        // True difference is below b, so W bits hold it exactly.
                        r_d = int_ge ? (r_sh[W-1:0] - b_q) : r_sh[W-1:0];
                        q_d = {q_q[W-2:0], int_ge};
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef GF_DIV_ZERO_FLAG_EN
            zf_q    <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef GF_DIV_ZERO_FLAG_EN
            zf_q    <= zf_d;
            dz_q    <= dz_d;
`endif
        end
    end

    // Working datapath needs no reset: it is fully loaded on every accepted start.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        gf_q  <= gf_d;
        deg_q <= deg_d;
        r_q   <= r_d;
        q_q   <= q_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;
`ifdef GF_DIV_ZERO_FLAG_EN
    assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_gf_divider.sv
// Self-checking bench for gf_divider: directed spec cases, start/busy rules, reset mid-op and random ops.
// Honours GF_DIV_ZERO_FLAG_EN when defined.
module tb_gf_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         gf_option;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
`ifdef GF_DIV_ZERO_FLAG_EN
    logic         dz;
`endif

    int n_vec;
    int n_err;

    gf_divider #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .gf_option (gf_option),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quo       (quo),
        .rem       (rem)
`ifdef GF_DIV_ZERO_FLAG_EN
        ,
        .div_by_zero (dz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int deg_of(input logic [W-1:0] v);
        int d;
        d = -1;
        for (int i = 0; i < W; i++) if (v[i]) d = i;
        return d;
    endfunction

    // Reference: plain arithmetic for integers, long division by degree for polynomials.
    task automatic ref_div(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ig,
                           output logic [W-1:0] oq, output logic [W-1:0] orr);
        int db;
        int s;
        oq  = '0;
        orr = ia;
`ifdef GF_DIV_ZERO_FLAG_EN
        if (ib == 0) return;
`endif
        if (!ig) begin
            if (ib == 0) oq = '1;
            else begin
                oq  = ia / ib;
                orr = ia % ib;
            end
        end else if (ib != 0) begin
            db = deg_of(ib);
            while (deg_of(orr) >= db) begin
                s   = deg_of(orr) - db;
                oq  = oq | (32'd1 << s);
                orr = orr ^ (ib << s);
            end
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] ib);
`ifdef GF_DIV_ZERO_FLAG_EN
        if (ib == 0) return 1;
`endif
        return W + 1;
    endfunction

    function automatic logic get_dz();
`ifdef GF_DIV_ZERO_FLAG_EN
        return dz;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one op and wait (bounded) for done; lat counts edges after the accepting edge.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ig,
                         output logic [W-1:0] oq, output logic [W-1:0] orr,
                         output int lat, output logic odz);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; gf_option = ig;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        oq  = quo;
        orr = rem;
        odz = get_dz();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; gf_option = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, quo, rem, get_dz()} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b quo=%h rem=%h dz=%b, expected all zero",
                     busy, done, quo, rem, get_dz());
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         g;
        logic [W-1:0] eq;
        logic [W-1:0] er;
    } dcase_t;

    task automatic test_directed;
        dcase_t tbl[9];
        logic [W-1:0] q, r;
        int lat;
        logic z;
        tbl[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2};
        tbl[1] = '{32'h57, 32'h3, 1'b1, 32'h32, 32'h1};
        tbl[2] = '{32'h57, 32'h3, 1'b0, 32'd29, 32'd0};
        tbl[3] = '{32'd10, 32'd25, 1'b0, 32'd0, 32'd10};
        tbl[4] = '{32'd28, 32'd72, 1'b1, 32'd0, 32'd28};
`ifdef GF_DIV_ZERO_FLAG_EN
        tbl[5] = '{32'd5, 32'd0, 1'b0, 32'd0, 32'd5};
`else
        tbl[5] = '{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5};
`endif
        tbl[6] = '{32'd5, 32'd0, 1'b1, 32'd0, 32'd5};
        tbl[7] = '{32'hDEADBEEF, 32'd1, 1'b0, 32'hDEADBEEF, 32'd0};
        tbl[8] = '{32'hDEADBEEF, 32'd1, 1'b1, 32'hDEADBEEF, 32'd0};
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].g, q, r, lat, z);
            n_vec++;
            if (q !== tbl[i].eq || r !== tbl[i].er) begin
                n_err++;
                $display("FAIL directed_%0d result: got quo=%h rem=%h, expected quo=%h rem=%h",
                         i, q, r, tbl[i].eq, tbl[i].er);
            end
            n_vec++;
            if (lat !== exp_lat(tbl[i].b)) begin
                n_err++;
                $display("FAIL directed_%0d latency: got %0d edges, expected %0d", i, lat, exp_lat(tbl[i].b));
            end
            n_vec++;
            if (z !== (tbl[i].b == 0 && exp_lat(tbl[i].b) == 1)) begin
                n_err++;
                $display("FAIL directed_%0d div_by_zero: got %b", i, z);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed_%0d pulse_end: got done=%b busy=%b, expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_busy_start;
        int pulses;
        logic [W-1:0] q, r, cq, cr;
        int lat;
        logic z;
        @(negedge clk);
        start = 1'b1; a = 32'd100; b = 32'd7; gf_option = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_accept: got %b, expected 1", busy);
        end
        repeat (5) @(negedge clk);
        start = 1'b1; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; cq = '0; cr = '0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin
                pulses++;
                cq = quo;
                cr = rem;
            end
            @(negedge clk);
        end
        n_vec++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL busy_done_count: got %0d pulses, expected 1", pulses);
        end
        n_vec++;
        if (cq !== 32'd14 || cr !== 32'd2) begin
            n_err++;
            $display("FAIL busy_ignore_start: got quo=%h rem=%h, expected 0000000e 00000002", cq, cr);
        end
        do_op(32'd9, 32'd3, 1'b0, q, r, lat, z);
        n_vec++;
        if (q !== 32'd3 || r !== 32'd0) begin
            n_err++;
            $display("FAIL busy_next_op: got quo=%h rem=%h, expected 3 0", q, r);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        logic [W-1:0] q, r;
        int lat;
        logic z;
        @(negedge clk);
        start = 1'b1; a = 32'd100; b = 32'd7; gf_option = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, quo, rem, get_dz()} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b quo=%h rem=%h, expected all zero",
                     busy, done, quo, rem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: got %0d pulses, expected 0", pulses);
        end
        do_op(32'd200, 32'd9, 1'b0, q, r, lat, z);
        n_vec++;
        if (q !== 32'd22 || r !== 32'd2 || lat !== W + 1) begin
            n_err++;
            $display("FAIL reset_mid_recover: got quo=%h rem=%h lat=%0d, expected 16 2 %0d", q, r, lat, W + 1);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] ra, rb, q, r, eq, er;
        logic rg, z;
        int lat, sel;
        for (int n = 0; n < 60; n++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = 32'd1;
            else if (sel < 5) rb = $urandom & ((32'd1 << $urandom_range(1, 16)) - 1);
            else rb = $urandom;
            rg = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rg, eq, er);
            do_op(ra, rb, rg, q, r, lat, z);
            n_vec++;
            if (q !== eq || r !== er || lat !== exp_lat(rb)) begin
                n_err++;
                $display("FAIL random_%0d a=%h b=%h gf=%b: got quo=%h rem=%h lat=%0d, expected quo=%h rem=%h lat=%0d",
                         n, ra, rb, rg, q, r, lat, eq, er, exp_lat(rb));
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
